// File: rtl/line_memory_responder_pkg.sv
// Shared definitions for the line-granular memory request interface used by
// the page-table walker, the cache replacers and the target-side responder.
package line_memory_responder_pkg;

  localparam int unsigned MEM_ADDR_WIDTH_DEF = 30;

  typedef logic [MEM_ADDR_WIDTH_DEF-1:0] line_addr_t;

  typedef enum logic [1:0] {
    MEM_REQ_NONE  = 2'd0,
    MEM_REQ_READ  = 2'd1,
    MEM_REQ_WRITE = 2'd2
  } mem_req_e;

  function automatic int unsigned beat_count(input int unsigned line_width,
                                             input int unsigned word_width);
    return line_width / word_width;
  endfunction

  function automatic int unsigned beat_idx_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Reads take priority so a replacer's fill is never starved by a writeback.
  function automatic mem_req_e mem_req_select(input logic rd_en, input logic wr_en);
    if (rd_en) return MEM_REQ_READ;
    if (wr_en) return MEM_REQ_WRITE;
    return MEM_REQ_NONE;
  endfunction

endpackage

// File: rtl/line_memory_responder_line_beat_buffer.sv
// Line-wide register with indexed word write (read assembly) and indexed
// word select (write serialization); whole-line load has priority.
module line_beat_buffer #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_load,
  input  logic [LINE_WIDTH-1:0] line_in,
  input  logic                  word_we,
  input  logic [IDX_WIDTH-1:0]  word_idx,
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic [LINE_WIDTH-1:0] line_out,
  output logic [WORD_WIDTH-1:0] word_out
);

  logic [LINE_WIDTH-1:0] line_d, line_q;

  always_comb begin
    line_d = line_q;
    if (line_load) begin
      line_d = line_in;
    end else if (word_we) begin
      line_d[word_idx*WORD_WIDTH +: WORD_WIDTH] = word_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line_out = line_q;
  assign word_out = line_q[word_idx*WORD_WIDTH +: WORD_WIDTH];

endmodule

// File: rtl/line_memory_responder.sv
// Target-side line memory responder: splits one full-line read or write into
// WORD_WIDTH beats over a ready/valid RAM port and pulses done on completion.
module line_memory_responder
  import line_memory_responder_pkg::*;
#(
  parameter int unsigned LINE_WIDTH     = 128,
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 30
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MEM_ADDR_WIDTH-1:0]  memAddr,
  input  logic                       memReadEnable,
  input  logic                       memWriteEnable,
  input  logic [LINE_WIDTH-1:0]      memWriteValue,
  output logic                       memReadDone,
  output logic                       memWriteDone,
  output logic [LINE_WIDTH-1:0]      memReadValue,
  output logic [MEM_ADDR_WIDTH+beat_idx_width(beat_count(LINE_WIDTH, WORD_WIDTH))-1:0] ramAddr,
  output logic                       ramReadEnable,
  output logic                       ramWriteEnable,
  output logic [WORD_WIDTH-1:0]      ramWriteValue,
  input  logic                       ramReady,
  input  logic                       ramReadValid,
  input  logic [WORD_WIDTH-1:0]      ramReadValue
);

  localparam int unsigned BEAT_COUNT = beat_count(LINE_WIDTH, WORD_WIDTH);
  localparam int unsigned IDX_W      = beat_idx_width(BEAT_COUNT);
  localparam int unsigned CNT_W      = IDX_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READ       = 3'd1,
    ST_READ_DONE  = 3'd2,
    ST_WRITE      = 3'd3,
    ST_WRITE_DONE = 3'd4
  } state_e;

  state_e                    state_d, state_q;
  logic [MEM_ADDR_WIDTH-1:0] line_addr_d, line_addr_q;
  logic [CNT_W-1:0]          issue_d, issue_q;
  logic [IDX_W-1:0]          recv_d, recv_q;
  mem_req_e                  req;
  logic                      rd_we, wr_load, ram_rd_en, ram_wr_en;
  logic [WORD_WIDTH-1:0]     wr_word, rd_word_unused;
  logic [LINE_WIDTH-1:0]     wr_line_unused;
  logic                      unused_sink;

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    issue_d     = issue_q;
    recv_d      = recv_q;
    rd_we       = 1'b0;
    wr_load     = 1'b0;
    req         = mem_req_select(memReadEnable, memWriteEnable);
    ram_rd_en   = (state_q == ST_READ) && (issue_q < CNT_W'(BEAT_COUNT));
    ram_wr_en   = (state_q == ST_WRITE);
    case (state_q)
      ST_IDLE: begin
        if (req != MEM_REQ_NONE) begin
          line_addr_d = memAddr;
          issue_d     = '0;
          recv_d      = '0;
          if (req == MEM_REQ_READ) begin
            state_d = ST_READ;
          end else begin
            wr_load = 1'b1;
            state_d = ST_WRITE;
          end
        end
      end
      ST_READ: begin
        // Issue and receive advance independently; returns may overlap issue.
        if (ram_rd_en && ramReady) issue_d = issue_q + CNT_W'(1);
        if (ramReadValid) begin
          rd_we  = 1'b1;
          recv_d = recv_q + IDX_W'(1);
          if (recv_q == IDX_W'(BEAT_COUNT - 1)) state_d = ST_READ_DONE;
        end
      end
      ST_WRITE: begin
        if (ramReady) begin
          issue_d = issue_q + CNT_W'(1);
          if (issue_q == CNT_W'(BEAT_COUNT - 1)) state_d = ST_WRITE_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      line_addr_q <= '0;
      issue_q     <= '0;
      recv_q      <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      issue_q     <= issue_d;
      recv_q      <= recv_d;
    end
  end

  // Separate buffers keep memReadValue stable across an intervening write.
  line_beat_buffer #(
    .LINE_WIDTH (LINE_WIDTH),
    .WORD_WIDTH (WORD_WIDTH),
    .IDX_WIDTH  (IDX_W)
  ) u_rd_buf (
    .clk       (clk),
    .rst       (rst),
    .line_load (1'b0),
    .line_in   ('0),
    .word_we   (rd_we),
    .word_idx  (recv_q),
    .word_in   (ramReadValue),
    .line_out  (memReadValue),
    .word_out  (rd_word_unused)
  );

  line_beat_buffer #(
    .LINE_WIDTH (LINE_WIDTH),
    .WORD_WIDTH (WORD_WIDTH),
    .IDX_WIDTH  (IDX_W)
  ) u_wr_buf (
    .clk       (clk),
    .rst       (rst),
    .line_load (wr_load),
    .line_in   (memWriteValue),
    .word_we   (1'b0),
    .word_idx  (issue_q[IDX_W-1:0]),
    .word_in   ('0),
    .line_out  (wr_line_unused),
    .word_out  (wr_word)
  );

  assign unused_sink    = ^{rd_word_unused, wr_line_unused};
  assign ramReadEnable  = ram_rd_en;
  assign ramWriteEnable = ram_wr_en;
  assign ramAddr        = (ram_rd_en || ram_wr_en) ? {line_addr_q, issue_q[IDX_W-1:0]} : '0;
  assign ramWriteValue  = ram_wr_en ? wr_word : '0;
  assign memReadDone    = (state_q == ST_READ_DONE);
  assign memWriteDone   = (state_q == ST_WRITE_DONE);

endmodule

// File: tb/tb_line_memory_responder.sv
// Self-checking bench for line_memory_responder: directed vector table, hand
// sequences for reset/arbitration/spurious returns, and randomized traffic.
module tb_line_memory_responder;

  localparam int LW = 128;
  localparam int WW = 32;
  localparam int AW = 30;
  localparam int LIMIT = 300;

  logic          clk, rst;
  logic [AW-1:0] memAddr;
  logic          memReadEnable, memWriteEnable;
  logic [LW-1:0] memWriteValue, memReadValue;
  logic          memReadDone, memWriteDone;
  logic [31:0]   ramAddr;
  logic          ramReadEnable, ramWriteEnable;
  logic [WW-1:0] ramWriteValue;
  logic          ramReady, ramReadValid;
  logic [WW-1:0] ramReadValue;

  line_memory_responder #(
    .LINE_WIDTH     (LW),
    .WORD_WIDTH     (WW),
    .MEM_ADDR_WIDTH (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .memAddr        (memAddr),
    .memReadEnable  (memReadEnable),
    .memWriteEnable (memWriteEnable),
    .memWriteValue  (memWriteValue),
    .memReadDone    (memReadDone),
    .memWriteDone   (memWriteDone),
    .memReadValue   (memReadValue),
    .ramAddr        (ramAddr),
    .ramReadEnable  (ramReadEnable),
    .ramWriteEnable (ramWriteEnable),
    .ramWriteValue  (ramWriteValue),
    .ramReady       (ramReady),
    .ramReadValid   (ramReadValid),
    .ramReadValue   (ramReadValue)
  );

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;

  // RAM model state and responder configuration
  logic [31:0] mem [logic [31:0]];
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend[$];
  logic [31:0] rd_log[$];
  logic [63:0] wr_log[$];
  int rdy_mode = 0, rdy_hold = 0, lat = 1, lat_rand = 0, vgap = 1;
  bit spurious = 0;
  int last_valid_c = -100;
  int rd_done_cnt = 0, wr_done_cnt = 0;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int            rdy_mode;
    int            hold0;
    int            vgap;
    int            exp_lat;
    bit            has_exp;
    logic [LW-1:0] exp_val;
  } vec_t;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // RAM responder: drives handshake inputs on the falling edge
  initial begin
    ramReady = 1'b0; ramReadValid = 1'b0; ramReadValue = '0;
    forever begin
      @(negedge clk);
      ramReadValid = 1'b0;
      ramReadValue = '0;
      if (pend.size() > 0 && pend[0].due <= cyc_cnt && (cyc_cnt - last_valid_c) >= vgap) begin
        ramReadValid = 1'b1;
        ramReadValue = ram_word(pend[0].addr);
        last_valid_c = cyc_cnt;
        void'(pend.pop_front());
      end else if (spurious) begin
        ramReadValid = 1'b1;
        ramReadValue = 32'hDEADBEEF;
      end
      if (rdy_hold > 0) begin
        ramReady = 1'b0;
        rdy_hold--;
      end else if (rdy_mode == 1) ramReady = !ramReady;
      else if (rdy_mode == 2) ramReady = ($urandom_range(0, 99) < 70);
      else ramReady = 1'b1;
      if (ramReadEnable && ramReady) begin
        pend.push_back('{addr: ramAddr, due: cyc_cnt + lat + (lat_rand != 0 ? int'($urandom_range(0, 2)) : 0)});
        rd_log.push_back(ramAddr);
      end
      if (ramWriteEnable && ramReady) begin
        mem[ramAddr] = ramWriteValue;
        wr_log.push_back({ramAddr, ramWriteValue});
      end
      if (memReadDone) rd_done_cnt++;
      if (memWriteDone) wr_done_cnt++;
      check("rw_exclusive", LW'(ramReadEnable && ramWriteEnable), '0);
    end
  end

  task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd,
                         input int exp_lat, input bit has_exp, input logic [LW-1:0] exp_val,
                         input string tag);
    logic [LW-1:0] exp_line;
    int cyc, d_rd, d_wr, t_done;
    for (int i = 0; i < 4; i++) exp_line[i*WW +: WW] = ram_word({a, 2'(i)});
    if (has_exp) exp_line = exp_val;
    rd_log.delete();
    wr_log.delete();
    d_rd = rd_done_cnt;
    d_wr = wr_done_cnt;
    @(negedge clk);
    memAddr = a;
    memWriteValue = wd;
    if (wr) memWriteEnable = 1'b1;
    else memReadEnable = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      memAddr = AW'($urandom);
      memWriteValue = {$urandom, $urandom, $urandom, $urandom};
    end while (!(wr ? memWriteDone : memReadDone) && cyc < LIMIT);
    t_done = cyc_cnt;
    memReadEnable = 1'b0;
    memWriteEnable = 1'b0;
    check({tag, " done_seen"}, LW'(cyc < LIMIT), LW'(1));
    if (exp_lat >= 0) check({tag, " latency"}, LW'(cyc), LW'(exp_lat));
    if (!wr) begin
      check({tag, " rd_value"}, memReadValue, exp_line);
      check({tag, " issue_count"}, LW'(rd_log.size()), LW'(4));
      for (int i = 0; i < 4; i++)
        if (i < rd_log.size()) check({tag, " rd_addr"}, LW'(rd_log[i]), LW'({a, 2'(i)}));
      check({tag, " done_after_last_valid"}, LW'(t_done), LW'(last_valid_c + 1));
    end else begin
      check({tag, " wr_beats"}, LW'(wr_log.size()), LW'(4));
      for (int i = 0; i < 4; i++)
        if (i < wr_log.size()) check({tag, " wr_beat"}, LW'(wr_log[i]), LW'({a, 2'(i), wd[i*WW +: WW]}));
    end
    repeat (3) @(negedge clk);
    check({tag, " rd_pulses"}, LW'(rd_done_cnt - d_rd), LW'(wr ? 0 : 1));
    check({tag, " wr_pulses"}, LW'(wr_done_cnt - d_wr), LW'(wr ? 1 : 0));
    if (!wr) check({tag, " rd_value_stable"}, memReadValue, exp_line);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " ctrl_outs"}, LW'({memReadDone, memWriteDone, ramReadEnable, ramWriteEnable}), '0);
    check({tag, " memReadValue"}, memReadValue, '0);
    check({tag, " ramAddr"}, LW'(ramAddr), '0);
    check({tag, " ramWriteValue"}, LW'(ramWriteValue), '0);
  endtask

  initial begin
    vec_t vecs[5];
    logic [LW-1:0] prev, exp_rd, wd;
    int cyc, d0, d1;

    vecs[0] = '{wr: 1'b0, addr: 30'h1234, wdata: '0, rdy_mode: 0, hold0: 0, vgap: 1, exp_lat: 6,
                has_exp: 1'b1, exp_val: 128'h000000A3_000000A2_000000A1_000000A0};
    vecs[1] = '{wr: 1'b1, addr: 30'h10, wdata: 128'h44444444_33333333_22222222_11111111, rdy_mode: 1,
                hold0: 0, vgap: 1, exp_lat: -1, has_exp: 1'b0, exp_val: '0};
    vecs[2] = '{wr: 1'b1, addr: 30'h3FFFFFFF, wdata: 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0, rdy_mode: 0,
                hold0: 0, vgap: 1, exp_lat: 5, has_exp: 1'b0, exp_val: '0};
    vecs[3] = '{wr: 1'b0, addr: 30'h10, wdata: '0, rdy_mode: 0, hold0: 0, vgap: 1, exp_lat: 6,
                has_exp: 1'b1, exp_val: 128'h44444444_33333333_22222222_11111111};
    vecs[4] = '{wr: 1'b0, addr: 30'h0, wdata: '0, rdy_mode: 0, hold0: 3, vgap: 2, exp_lat: -1,
                has_exp: 1'b0, exp_val: '0};

    for (int i = 0; i < 4; i++) mem[32'h48D0 + i] = 32'hA0 + i;

    rst = 1'b0;
    memAddr = '0; memReadEnable = 1'b0; memWriteEnable = 1'b0; memWriteValue = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      rdy_mode = vecs[i].rdy_mode;
      vgap = vecs[i].vgap;
      lat = 1;
      lat_rand = 0;
      @(negedge clk);
      rdy_hold = vecs[i].hold0;
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_lat, vecs[i].has_exp,
              vecs[i].exp_val, $sformatf("vec%0d", i));
    end

    // Read and write requested together: read first, write afterwards.
    rdy_mode = 0; vgap = 1; lat = 1;
    wd = 128'h0F0F0F0F_E1E1E1E1_D2D2D2D2_C3C3C3C3;
    for (int i = 0; i < 4; i++) exp_rd[i*WW +: WW] = ram_word({30'h55, 2'(i)});
    wr_log.delete();
    d0 = rd_done_cnt;
    d1 = wr_done_cnt;
    @(negedge clk);
    memAddr = 30'h55; memWriteValue = wd; memReadEnable = 1'b1; memWriteEnable = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!memReadDone && cyc < LIMIT);
    memReadEnable = 1'b0;
    check("both rd_done_seen", LW'(cyc < LIMIT), LW'(1));
    check("both no_write_during_read", LW'(wr_log.size()), '0);
    check("both rd_value", memReadValue, exp_rd);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!memWriteDone && cyc < LIMIT);
    memWriteEnable = 1'b0;
    check("both wr_done_seen", LW'(cyc < LIMIT), LW'(1));
    check("both wr_beats", LW'(wr_log.size()), LW'(4));
    for (int i = 0; i < 4; i++)
      if (i < wr_log.size()) check("both wr_beat", LW'(wr_log[i]), LW'({30'h55, 2'(i), wd[i*WW +: WW]}));
    repeat (2) @(negedge clk);
    check("both pulses", LW'({rd_done_cnt - d0, wr_done_cnt - d1}), LW'({32'd1, 32'd1}));

    // Reset in the middle of a read with returns still in flight.
    lat = 3;
    d0 = rd_done_cnt;
    rd_log.delete();
    @(negedge clk);
    memAddr = 30'h77; memReadEnable = 1'b1;
    cyc = 0;
    while (rd_log.size() < 2 && cyc < 50) begin @(negedge clk); cyc++; end
    check("rst_mid two_beats_issued", LW'(cyc < 50), LW'(1));
    rst = 1'b0;
    memReadEnable = 1'b0;
    @(negedge clk);
    check_outputs_zero("rst_mid");
    rst = 1'b1;
    cyc = 0;
    while (pend.size() > 0 && cyc < 20) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);
    check("rst_mid late_returns_drained", LW'(pend.size()), '0);
    check("rst_mid late_valid_ignored", memReadValue, '0);
    check("rst_mid no_done", LW'(rd_done_cnt - d0), '0);
    lat = 1;
    run_txn(1'b0, 30'h20, '0, 6, 1'b0, '0, "after_rst");

    // Spurious read-valid while idle.
    prev = memReadValue;
    d0 = rd_done_cnt;
    spurious = 1'b1;
    repeat (4) @(negedge clk);
    spurious = 1'b0;
    repeat (2) @(negedge clk);
    check("spurious value_unchanged", memReadValue, prev);
    check("spurious no_done", LW'(rd_done_cnt - d0), '0);
    check("spurious still_idle", LW'({ramReadEnable, ramWriteEnable}), '0);

    // Randomized traffic against the line-level model.
    rdy_mode = 2;
    lat_rand = 1;
    for (int n = 0; n < 24; n++) begin
      vgap = int'($urandom_range(1, 2));
      run_txn(1'($urandom_range(0, 1)), 30'h100 + 30'($urandom_range(0, 7)),
              {$urandom, $urandom, $urandom, $urandom}, -1, 1'b0, '0, $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_memory_responder.md
Name: line_memory_responder

Overview:
- Target-side end of the line-granular memory request interface used by the page-table walker and the cache replacers.
- Accepts one full-line read or write request, then executes it as WORD_WIDTH-wide beats over a narrow RAM port with a ready/valid handshake.
- Signals completion with a single-cycle done pulse.
- Sits between one line-level initiator and the on-chip RAM/bus bridge.

Parameters:
LINE_WIDTH, 128, line width in bits; must be a multiple of WORD_WIDTH.
WORD_WIDTH, 32, RAM port data width in bits.
MEM_ADDR_WIDTH, 30, line address width (PADDR_WIDTH minus log2 of line bytes).
BEAT_COUNT, LINE_WIDTH/WORD_WIDTH, beats per line (derived localparam, power of two ≥2).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (rst==0 resets)
memAddr  in  MEM_ADDR_WIDTH  line address of request
memReadEnable  in  1  line read request; held until memReadDone
memWriteEnable  in  1  line write request; held until memWriteDone
memWriteValue  in  LINE_WIDTH  line data to write
memReadDone  out  1  one-cycle pulse, read complete
memWriteDone  out  1  one-cycle pulse, write complete
memReadValue  out  LINE_WIDTH  assembled read line
ramAddr  out  MEM_ADDR_WIDTH+log2(BEAT_COUNT)  word address {lineAddr, beatIndex}
ramReadEnable  out  1  word read request
ramWriteEnable  out  1  word write request
ramWriteValue  out  WORD_WIDTH  word write data
ramReady  in  1  RAM accepts request this cycle
ramReadValid  in  1  read data returned this cycle
ramReadValue  in  WORD_WIDTH  returned read word

Behaviour:
- Reset (rst==0 at posedge): state Idle, all counters 0, memReadValue 0, all outputs 0. Reset mid-operation aborts in-flight beats; read data still in flight afterwards is ignored.
- States: Idle, Read, ReadDone, Write, WriteDone.
- Idle:
  - memReadEnable=1: latch memAddr, clear issue/receive counters, go to Read.
  - Else memWriteEnable=1: latch memAddr and memWriteValue, go to Write.
  - Both asserted: read wins; the write is seen after the read completes if still held.
- Read:
  - ramReadEnable=1 while issueCount<BEAT_COUNT; ramAddr={lineAddr, issueCount}.
  - issueCount increments on ramReadEnable&&ramReady.
  - Returns arrive in order, latency ≥1, possibly while issue continues. Each ramReadValid writes ramReadValue into memReadValue[recvCount*WORD_WIDTH +: WORD_WIDTH] and increments recvCount.
  - Go to ReadDone on the cycle the last beat is received (recvCount==BEAT_COUNT-1 && ramReadValid).
- ReadDone: memReadDone=1 for exactly one cycle, then Idle.
  - memReadValue is stable from the ReadDone cycle until the next read's first returned beat.
  - The initiator drops its enable the cycle after done, so Idle never re-accepts the same request.
- Write:
  - ramWriteEnable=1, ramAddr={lineAddr, issueCount}, ramWriteValue=latched line[issueCount*WORD_WIDTH +: WORD_WIDTH].
  - Advance on ramReady; after beat BEAT_COUNT-1 is accepted, go to WriteDone.
- WriteDone: memWriteDone=1 for one cycle, then Idle.
- Beat 0 is the least-significant word; the beat counter wraps only by state exit, never mid-line.
- ramReadValid outside Read: ignored, no state change.
- Minimum latency with ramReady=1 and 1-cycle read return:
  - Read: BEAT_COUNT+2 cycles from accept to done.
  - Write: BEAT_COUNT+1 cycles.
- Changes to memAddr/memWriteValue after accept have no effect.
- ramReadEnable and ramWriteEnable are never both 1. Request outputs are 0 outside Read/Write.

Decomposition:
- Shared memory-interface package: line address typedef, BEAT_COUNT/beat index width helpers, and the read/write request enum reused by the replacers.
- State enum stays local to the module.
- One natural sub-module: line_beat_buffer, a LINE_WIDTH register with indexed word write (read assembly) and indexed word select (write serialization).

Test Plan:
- Single read, LINE_WIDTH=128, ramReady=1, 1-cycle return, memAddr=0x1234, RAM words 0xA0..0xA3 → ramAddr 0x48D0..0x48D3, memReadDone pulses once at cycle 6, memReadValue=0x000000A3_000000A2_000000A1_000000A0.
- Write memAddr=0x10, memWriteValue=0x44444444_33333333_22222222_11111111, ramReady toggling 1,0,1,0,... → words 0x11111111..0x44444444 written to 0x40..0x43 in order, exactly one memWriteDone pulse after the 4th accepted beat.
- Read with ramReady=0 for 3 cycles, then returns spaced 2 cycles apart → no premature done; done exactly one cycle after the 4th ramReadValid; issue count never exceeds 4.
- memReadEnable and memWriteEnable both high in Idle → read serviced first and memReadDone pulses; the write then starts and memWriteDone pulses; ramWriteEnable stays 0 during the read.
- Reset (rst=0) asserted after 2 read beats → all outputs 0 next cycle; late ramReadValid ignored; a subsequent read to 0x20 completes correctly.
- Spurious ramReadValid=1 in Idle with value 0xDEADBEEF → memReadValue unchanged, no done pulse.
